// File: rtl/axi_pkg.sv
// Shared AXI4 constants for the burst DMA and its local memory.
// Holds default widths, the fixed burst attributes driven on AW/AR, and a
// helper that turns a data-bus width into the AXI SIZE encoding.
package axi_pkg;

  localparam int DEF_AXI_ADDR_WIDTH = 32;
  localparam int DEF_AXI_DATA_WIDTH = 32;
  localparam int DEF_BURST_LEN      = 16;
  localparam int DEF_MEM_ADDR_WIDTH = 10;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_DEF  = 4'b0011;   // normal, non-cacheable, bufferable
  localparam logic [2:0] PROT_DEF   = 3'b000;
  localparam logic [3:0] QOS_DEF    = 4'b0000;

  // log2 of bytes per beat; widths that are not a power of two map to 0
  function automatic logic [2:0] axi_size(input int data_width);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == (data_width / 8)) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/logic_mem.sv
// Local dual-port RAM of 2^ADDR_WIDTH words feeding the burst DMA.
// Ports:
//   clk, rst_n               clock, async active-low reset (clears rd_dat_vld only)
//   rd_en, rd_addr           read request; data returns one cycle later
//   rd_dat_vld, rd_data      registered read data and its valid flag
//   wr_en, wr_addr, wr_data  synchronous write port
module logic_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_dat_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // array and read register carry no reset so they map onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_dat_vld <= 1'b0;
    else        rd_dat_vld <= rd_en;
  end

endmodule

// File: rtl/burst_axi_dma.sv
// Single-burst AXI4 master DMA with independent write and read engines.
// Write engine: fetches BURST_LEN words from local memory and sends them as
// one INCR burst on AW/W/B. Read engine: fetches one INCR burst on AR/R and
// stores each beat into local memory.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN          clock, async active-low reset
//   awaddr, mem_base_waddr, start_dma_w AXI dest / local source, start pulse
//   araddr, mem_base_raddr, start_dma_r AXI source / local dest, start pulse
//   dma_w_done, dma_r_done              one-cycle completion pulses
//   rd_en/rd_addr/rd_dat_vld/rd_data    local memory read port
//   wr_en/wr_addr/wr_data               local memory write port
//   M_AXI_AW*/W*/B*/AR*/R*              AXI4 master channels
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for start_dma_w
//   W_AW   | AWVALID held until AWREADY
//   W_DATA | fetch word, present on W, wait for WREADY, repeat
//   W_RESP | BREADY held until BVALID
//   W_DONE | dma_w_done pulse
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for start_dma_r
//   R_AR   | ARVALID held until ARREADY
//   R_DATA | RREADY high, each beat written straight to local memory
//   R_DONE | dma_r_done pulse
module burst_axi_dma
  import axi_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH     = 1,
  parameter int C_M_AXI_ADDR_WIDTH   = DEF_AXI_ADDR_WIDTH,
  parameter int C_M_AXI_DATA_WIDTH   = DEF_AXI_DATA_WIDTH,
  parameter int C_M_AXI_BURST_LEN    = DEF_BURST_LEN,
  parameter int ADDR_WIDTH           = DEF_MEM_ADDR_WIDTH,
  parameter int C_M_AXI_AWUSER_WIDTH = 1,
  parameter int C_M_AXI_ARUSER_WIDTH = 1,
  parameter int C_M_AXI_WUSER_WIDTH  = 1,
  parameter int C_M_AXI_RUSER_WIDTH  = 1,
  parameter int C_M_AXI_BUSER_WIDTH  = 1
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     araddr,
  input  logic [ADDR_WIDTH-1:0]             mem_base_waddr,
  input  logic [ADDR_WIDTH-1:0]             mem_base_raddr,
  input  logic                              start_dma_w,
  input  logic                              start_dma_r,
  output logic                              dma_w_done,
  output logic                              dma_r_done,
  output logic                              rd_en,
  output logic [ADDR_WIDTH-1:0]             rd_addr,
  input  logic                              rd_dat_vld,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     rd_data,
  output logic                              wr_en,
  output logic [ADDR_WIDTH-1:0]             wr_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     wr_data,
  output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic [2:0]                        M_AXI_AWSIZE,
  output logic [1:0]                        M_AXI_AWBURST,
  output logic                              M_AXI_AWLOCK,
  output logic [3:0]                        M_AXI_AWCACHE,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic [3:0]                        M_AXI_AWQOS,
  output logic [C_M_AXI_AWUSER_WIDTH-1:0]   M_AXI_AWUSER,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic [C_M_AXI_WUSER_WIDTH-1:0]    M_AXI_WUSER,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic [C_M_AXI_BUSER_WIDTH-1:0]    M_AXI_BUSER,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                        M_AXI_ARLEN,
  output logic [2:0]                        M_AXI_ARSIZE,
  output logic [1:0]                        M_AXI_ARBURST,
  output logic                              M_AXI_ARLOCK,
  output logic [3:0]                        M_AXI_ARCACHE,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic [3:0]                        M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0]   M_AXI_ARUSER,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RLAST,
  input  logic [C_M_AXI_RUSER_WIDTH-1:0]    M_AXI_RUSER,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam logic [2:0] W_IDLE = 3'd0;
  localparam logic [2:0] W_AW   = 3'd1;
  localparam logic [2:0] W_DATA = 3'd2;
  localparam logic [2:0] W_RESP = 3'd3;
  localparam logic [2:0] W_DONE = 3'd4;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_DONE = 2'd3;

  localparam logic [7:0] LEN  = 8'(C_M_AXI_BURST_LEN - 1);
  localparam logic [2:0] SIZE = axi_size(C_M_AXI_DATA_WIDTH);

  logic [2:0]                        w_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr_q;
  logic [ADDR_WIDTH-1:0]             rd_addr_q;
  logic                              rd_en_q;
  logic [7:0]                        w_remain;   // beats left after the current one
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic                              wvalid_q;

  logic [1:0]                        r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     araddr_q;
  logic [ADDR_WIDTH-1:0]             wr_base_q;
  logic [ADDR_WIDTH-1:0]             r_beat;
  logic [7:0]                        r_remain;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      w_state   <= W_IDLE;
      awaddr_q  <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      w_remain  <= '0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (start_dma_w) begin
          awaddr_q  <= awaddr;
          rd_addr_q <= mem_base_waddr;
          w_remain  <= LEN;
          w_state   <= W_AW;
        end
        W_AW: if (M_AXI_AWREADY) begin
          rd_en_q <= 1'b1;
          w_state <= W_DATA;
        end
        W_DATA: begin
          rd_en_q <= 1'b0;
          if (rd_dat_vld && !wvalid_q) begin
            wdata_q  <= rd_data;
            wvalid_q <= 1'b1;
          end
          // next fetch only after the current beat is taken, so the
          // holding register never needs a second slot
          if (wvalid_q && M_AXI_WREADY) begin
            wvalid_q <= 1'b0;
            if (w_remain == 8'd0) begin
              w_state <= W_RESP;
            end else begin
              w_remain  <= w_remain - 1'b1;
              rd_addr_q <= rd_addr_q + 1'b1;
              rd_en_q   <= 1'b1;
            end
          end
        end
        W_RESP: if (M_AXI_BVALID) w_state <= W_DONE;
        W_DONE: w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state   <= R_IDLE;
      araddr_q  <= '0;
      wr_base_q <= '0;
      r_beat    <= '0;
      r_remain  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (start_dma_r) begin
          araddr_q  <= araddr;
          wr_base_q <= mem_base_raddr;
          r_beat    <= '0;
          r_remain  <= LEN;
          r_state   <= R_AR;
        end
        R_AR: if (M_AXI_ARREADY) r_state <= R_DATA;
        R_DATA: if (M_AXI_RVALID) begin
          r_beat <= r_beat + 1'b1;
          // an early RLAST or a full burst both end the transfer
          if (M_AXI_RLAST || r_remain == 8'd0) r_state <= R_DONE;
          else                                  r_remain <= r_remain - 1'b1;
        end
        R_DONE: r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = LEN;
  assign M_AXI_AWSIZE  = SIZE;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = CACHE_DEF;
  assign M_AXI_AWPROT  = PROT_DEF;
  assign M_AXI_AWQOS   = QOS_DEF;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_AWVALID = (w_state == W_AW);
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = wvalid_q && (w_remain == 8'd0);
  assign M_AXI_WUSER   = '0;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (w_state == W_RESP);
  assign dma_w_done    = (w_state == W_DONE);
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = LEN;
  assign M_AXI_ARSIZE  = SIZE;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = CACHE_DEF;
  assign M_AXI_ARPROT  = PROT_DEF;
  assign M_AXI_ARQOS   = QOS_DEF;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARVALID = (r_state == R_AR);
  assign M_AXI_RREADY  = (r_state == R_DATA);
  assign dma_r_done    = (r_state == R_DONE);

  // read beats go straight to memory in the cycle they are accepted
  assign wr_en   = M_AXI_RREADY && M_AXI_RVALID;
  assign wr_addr = wr_base_q + r_beat;
  assign wr_data = M_AXI_RDATA;

  // response IDs, codes and user bits carry no information for this engine
  logic unused_resp;
  assign unused_resp = ^{M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER,
                         M_AXI_RID, M_AXI_RRESP, M_AXI_RUSER};

endmodule

// File: tb/tb_burst_axi_dma.sv
module tb_burst_axi_dma;

  localparam int IDW = 1;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BL  = 16;
  localparam int MAW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   awaddr, araddr;
  logic [MAW-1:0]  mem_base_waddr, mem_base_raddr;
  logic            start_dma_w, start_dma_r, dma_w_done, dma_r_done;
  logic            rd_en, rd_dat_vld, wr_en;
  logic [MAW-1:0]  rd_addr, wr_addr;
  logic [DW-1:0]   rd_data, wr_data;
  logic [IDW-1:0]  awid, arid, bid, rid;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize, awprot, arprot;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awlock, arlock, awvalid, awready, arvalid, arready;
  logic [3:0]      awcache, arcache, awqos, arqos, wstrb;
  logic            awuser, aruser, wuser, buser, ruser;
  logic [DW-1:0]   wdata, rdata;
  logic            wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  burst_axi_dma #(.C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_ADDR_WIDTH(AW),
                  .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_BURST_LEN(BL),
                  .ADDR_WIDTH(MAW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .awaddr(awaddr), .araddr(araddr),
    .mem_base_waddr(mem_base_waddr), .mem_base_raddr(mem_base_raddr),
    .start_dma_w(start_dma_w), .start_dma_r(start_dma_r),
    .dma_w_done(dma_w_done), .dma_r_done(dma_r_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dat_vld(rd_dat_vld), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(m_awaddr), .M_AXI_AWLEN(awlen),
    .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock),
    .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
    .M_AXI_AWUSER(awuser), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WUSER(wuser), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BUSER(buser),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(m_araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
    .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARUSER(aruser), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RUSER(ruser), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  logic_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(MAW)) u_mem (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dat_vld(rd_dat_vld), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct {
    logic [MAW-1:0] addr;
    logic [DW-1:0]  data;
  } wr_exp_t;

  wr_exp_t       r_q[$];
  logic [DW-1:0] w_q[$];
  wr_exp_t       r_e;
  logic [DW-1:0] w_e;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor: scoreboard pops, W stability, done counting
  int   w_cnt = 0, w_idx = 0, w_done_cnt = 0, r_done_cnt = 0;
  logic w_hold = 1'b0;
  logic [DW-1:0] w_hold_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (r_q.size() == 0) check("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
        else begin
          r_e = r_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(r_e.addr));
          check("wr_data", wr_data, r_e.data);
        end
      end
      if (w_hold) begin
        check("w_valid_hold", 32'(wvalid), 32'd1);
        check("w_data_hold", wdata, w_hold_data);
      end
      w_hold = wvalid && !wready;
      w_hold_data = wdata;
      if (wvalid && wready) begin
        if (w_q.size() == 0) check("w_unexpected", wdata, 32'hDEAD_BEEF);
        else begin
          w_e = w_q.pop_front();
          check("w_data", wdata, w_e);
        end
        check("w_last", 32'(wlast), 32'(w_idx == BL - 1));
        check("w_strb", 32'(wstrb), 32'hF);
        w_idx = (w_idx == BL - 1) ? 0 : w_idx + 1;
        w_cnt++;
      end
      if (dma_w_done) w_done_cnt++;
      if (dma_r_done) r_done_cnt++;
    end else begin
      w_hold = 1'b0;
      w_idx  = 0;
    end
  end

  // W-channel ready driver: random stalls on request, forced low on block
  bit w_rand = 1'b0, w_block = 1'b0;
  initial begin
    wready = 1'b0;
    forever begin
      @(posedge clk); #1;
      wready = w_block ? 1'b0 : (w_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_quiet(input string tag);
    check({tag, "_awvalid"}, 32'(awvalid), 0);
    check({tag, "_wvalid"},  32'(wvalid),  0);
    check({tag, "_wlast"},   32'(wlast),   0);
    check({tag, "_bready"},  32'(bready),  0);
    check({tag, "_arvalid"}, 32'(arvalid), 0);
    check({tag, "_rready"},  32'(rready),  0);
    check({tag, "_rd_en"},   32'(rd_en),   0);
    check({tag, "_wr_en"},   32'(wr_en),   0);
    check({tag, "_w_done"},  32'(dma_w_done), 0);
    check({tag, "_r_done"},  32'(dma_r_done), 0);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [MAW-1:0] base,
                          input logic [31:0] dbase, input int last_at, input bit rlast_en,
                          input int ar_stall, input bit extra, input bit repulse);
    int d0, cnt;
    d0 = r_done_cnt;
    @(posedge clk); #1;
    araddr = addr; mem_base_raddr = base; start_dma_r = 1'b1;
    @(posedge clk); #1;
    start_dma_r = 1'b0; araddr = ~addr; mem_base_raddr = ~base;
    @(negedge clk);
    check("ar_valid", 32'(arvalid), 1);
    check("ar_addr", m_araddr, addr);
    check("ar_len", 32'(arlen), BL - 1);
    check("ar_size", 32'(arsize), 2);
    check("ar_burst", 32'(arburst), 1);
    for (int i = 0; i < ar_stall; i++) begin
      @(negedge clk);
      check("ar_valid_stall", 32'(arvalid), 1);
      check("ar_addr_stall", m_araddr, addr);
    end
    @(posedge clk); #1 arready = 1'b1;
    @(negedge clk);
    check("ar_valid_hs", 32'(arvalid), 1);
    @(posedge clk); #1 arready = 1'b0;
    for (int i = 0; i <= last_at; i++) begin
      rvalid = 1'b1;
      rdata  = dbase + 32'(i);
      rlast  = rlast_en && (i == last_at);
      if (repulse) start_dma_r = (i == 5);
      r_q.push_back('{addr: base + MAW'(i), data: dbase + 32'(i)});
      cnt = 0;
      @(negedge clk);
      while (!rready && cnt < 50) begin cnt++; @(negedge clk); end
      if (cnt >= 50) check("r_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0; start_dma_r = 1'b0;
    if (extra) begin
      rvalid = 1'b1; rdata = dbase + 32'(last_at + 1); rlast = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("r_ready_after_end", 32'(rready), 0);
      end
      @(posedge clk); #1 rvalid = 1'b0; rlast = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("r_done_once", 32'(r_done_cnt - d0), 1);
    check("r_q_drained", 32'(r_q.size()), 0);
    check("ar_idle_after", 32'(arvalid), 0);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [MAW-1:0] base,
                           input logic [31:0] dbase, input int aw_stall, input bit stall_en);
    int d0, c0, cnt;
    d0 = w_done_cnt; c0 = w_cnt;
    for (int i = 0; i < BL; i++) w_q.push_back(dbase + 32'(i));
    w_rand = stall_en;
    @(posedge clk); #1;
    awaddr = addr; mem_base_waddr = base; start_dma_w = 1'b1;
    @(posedge clk); #1;
    start_dma_w = 1'b0; awaddr = ~addr; mem_base_waddr = ~base;
    @(negedge clk);
    check("aw_valid", 32'(awvalid), 1);
    check("aw_addr", m_awaddr, addr);
    check("aw_len", 32'(awlen), BL - 1);
    check("aw_size", 32'(awsize), 2);
    check("aw_burst", 32'(awburst), 1);
    check("aw_cache", 32'(awcache), 3);
    for (int i = 0; i < aw_stall; i++) begin
      @(negedge clk);
      check("aw_valid_stall", 32'(awvalid), 1);
      check("aw_addr_stall", m_awaddr, addr);
    end
    @(posedge clk); #1 awready = 1'b1;
    @(posedge clk); #1 awready = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (!bready && cnt < 1000) begin cnt++; @(negedge clk); end
    if (cnt >= 1000) check("b_ready_timeout", 0, 1);
    w_rand = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("b_ready_hold", 32'(bready), 1);
      check("w_done_early", 32'(dma_w_done), 0);
    end
    @(posedge clk); #1 bvalid = 1'b1; bresp = 2'b10;
    @(negedge clk);
    check("b_ready_hs", 32'(bready), 1);
    @(posedge clk); #1 bvalid = 1'b0; bresp = 2'b00;
    repeat (3) @(negedge clk);
    check("w_done_once", 32'(w_done_cnt - d0), 1);
    check("w_beats", 32'(w_cnt - c0), BL);
    check("w_q_drained", 32'(w_q.size()), 0);
    check("b_ready_after", 32'(bready), 0);
  endtask

  initial begin
    int dw0, dr0;
    awaddr = '0; araddr = '0; mem_base_waddr = '0; mem_base_raddr = '0;
    start_dma_w = 1'b0; start_dma_r = 1'b0;
    awready = 1'b0; arready = 1'b0;
    bid = '0; bresp = '0; buser = '0; bvalid = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; ruser = '0; rvalid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("static_wstrb", 32'(wstrb), 32'hF);
    check("static_awlen", 32'(awlen), BL - 1);
    check("static_awprot", 32'(awprot), 0);
    check("static_arcache", 32'(arcache), 3);
    check("static_ids", 32'({awid, arid}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // full read burst into mem[0..15]
    run_read(32'h100, 10'h000, 32'h0, 15, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < BL; i += 5) check("mem_after_read", u_mem.mem[i], 32'(i));

    // early RLAST on beat 14, extra beat must be refused
    run_read(32'h200, 10'h040, 32'h300, 14, 1'b1, 0, 1'b1, 1'b0);

    // no RLAST at all: beat count ends the burst; local address wraps
    run_read(32'h180, 10'h3F8, 32'h500, 15, 1'b0, 0, 1'b1, 1'b0);

    // preload mem[0x20..0x2F] with ARREADY held low for 5 cycles
    run_read(32'h280, 10'h020, 32'hA0, 15, 1'b1, 5, 1'b0, 1'b0);

    // write burst with random WREADY stalls and AW backpressure
    run_write(32'h400, 10'h020, 32'hA0, 2, 1'b1);

    // concurrent write (wrapping source) and read with a busy re-pulse
    fork
      run_write(32'h600, 10'h3F8, 32'h500, 0, 1'b1);
      run_read(32'h300, 10'h100, 32'h700, 15, 1'b1, 0, 1'b1, 1'b1);
    join

    // reset in the middle of both bursts
    w_block = 1'b1;
    @(posedge clk); #1;
    awaddr = 32'h800; mem_base_waddr = 10'h000; start_dma_w = 1'b1;
    araddr = 32'h900; mem_base_raddr = 10'h200; start_dma_r = 1'b1;
    @(posedge clk); #1;
    start_dma_w = 1'b0; start_dma_r = 1'b0; awready = 1'b1; arready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0; arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rdata = 32'hC00 + 32'(i);
      r_q.push_back('{addr: 10'h200 + MAW'(i), data: 32'hC00 + 32'(i)});
      @(negedge clk);
      check("rst_pre_rready", 32'(rready), 1);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pre_wvalid", 32'(wvalid), 1);
    dw0 = w_done_cnt; dr0 = r_done_cnt;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid");
    @(posedge clk); #1 rst_n = 1'b1; w_block = 1'b0;
    repeat (4) @(negedge clk);
    check_quiet("rst_after");
    check("rst_no_w_done", 32'(w_done_cnt - dw0), 0);
    check("rst_no_r_done", 32'(r_done_cnt - dr0), 0);
    w_q.delete();
    r_q.delete();

    // normal operation after the abort
    run_read(32'h140, 10'h080, 32'hE00, 15, 1'b1, 0, 1'b0, 1'b0);
    run_write(32'h840, 10'h080, 32'hE00, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
